dm_stage_mem: RTL and testbench

- Data memory of the M stage in the 5-stage MIPS pipeline.
- Performs word, halfword and byte stores using a synchronous write.
- Returns sign- or zero-extended load data combinationally on rdata, which drives DM_in of the M/W pipeline register.
- Address and write data come from the E/M register; the controller supplies the access type.

---
 rtl/dm_stage_mem.sv | 154 +++++++++++++++
 tb/tb_dm_stage_mem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dm_stage_mem.sv
// Data memory for the M stage: word/half/byte stores, sign/zero-extended loads.
// Latency: stores commit at the next posedge; loads are combinational (0 clocks).
// Backpressure: none; every cycle is accepted, illegal accesses are dropped via align_err.
module dm_stage_mem #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter bit          LOG_WRITES  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        align_err
);

    // Access type encodings shared by load and store paths.
    localparam logic [2:0] OP_WORD = 3'b000;
    localparam logic [2:0] OP_HU   = 3'b001;
    localparam logic [2:0] OP_HS   = 3'b010;
    localparam logic [2:0] OP_BU   = 3'b011;
    localparam logic [2:0] OP_BS   = 3'b100;

    // Enough index bits to cover every word in the array.
    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic          in_range;
    logic          misaligned;
    logic [IW-1:0] idx;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;
    logic [31:0]   ext_data;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;
    logic [31:0]   merged;
    logic          commit;

    // The full 30-bit word index is range-checked, so high address bits
    // never alias onto a valid word.
    assign in_range = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    assign idx      = addr[IW+1:2];

    // Alignment rules per access width; reserved codes are always illegal.
    always_comb begin
        misaligned = 1'b0;
        case (op)
            OP_WORD:      misaligned = (addr[1:0] != 2'b00);
            OP_HU, OP_HS: misaligned = addr[0];
            OP_BU, OP_BS: misaligned = 1'b0;
            default:      misaligned = 1'b1;
        endcase
    end

    assign align_err = misaligned | ~in_range;

    // Out-of-range addresses never touch the array, keeping the read in bounds.
    assign rd_word = in_range ? mem[idx] : 32'h0;

    // Lane selection for sub-word loads.
    always_comb begin
        rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte = rd_word[7:0];
        case (addr[1:0])
            2'b00: rd_byte = rd_word[7:0];
            2'b01: rd_byte = rd_word[15:8];
            2'b10: rd_byte = rd_word[23:16];
            2'b11: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
    end

    // Sign/zero extension by access type.
    always_comb begin
        ext_data = 32'h0;
        case (op)
            OP_WORD: ext_data = rd_word;
            OP_HU:   ext_data = {16'h0, rd_half};
            OP_HS:   ext_data = {{16{rd_half[15]}}, rd_half};
            OP_BU:   ext_data = {24'h0, rd_byte};
            OP_BS:   ext_data = {{24{rd_byte[7]}}, rd_byte};
            default: ext_data = 32'h0;
        endcase
    end

    // An illegal access reads as zero so the M/W register never captures junk.
    assign rdata = align_err ? 32'h0 : ext_data;

    // Byte enables and replicated store data; signed/unsigned codes store alike.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = wdata;
        case (op)
            OP_WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = wdata;
            end
            OP_HU, OP_HS: begin
                byte_en  = addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{wdata[15:0]}};
            end
            OP_BU, OP_BS: begin
                byte_en  = 4'b0001 << addr[1:0];
                wr_lanes = {4{wdata[7:0]}};
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = wdata;
            end
        endcase
    end

    // Merge enabled lanes into the current word so partial stores accumulate.
    always_comb begin
        merged = rd_word;
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged[b*8 +: 8] = wr_lanes[b*8 +: 8];
            end
        end
    end

    // Reset wins over a concurrent store; illegal stores are silently dropped.
    assign commit = ~reset & WE & ~align_err;

    // Array update: full clear on reset, otherwise commit the merged word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

    generate
        if (LOG_WRITES) begin : g_log
`ifndef SYNTHESIS
            // Simulation trace of each committed store as the full merged word.
            always_ff @(posedge clk) begin
                if (commit) begin
                    $write("@%h: *%h <= %h\n", pc, {addr[31:2], 2'b00}, merged);
                end
            end
`endif
        end
    endgenerate

endmodule

// File: tb/tb_dm_stage_mem.sv
module tb_dm_stage_mem;

    localparam int unsigned DEPTH = 3072;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        align_err;

    int total = 0;
    int bad   = 0;

    // Scoreboard: expected results queued when stimulus is applied.
    logic [31:0] exp_q [$];
    logic        err_q [$];

    dm_stage_mem #(
        .DEPTH_WORDS(DEPTH),
        .LOG_WRITES (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .WE       (WE),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .pc       (pc),
        .rdata    (rdata),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Pop the oldest expectation and compare both outputs against it.
    task automatic compare(input string tag);
        logic [31:0] e_dat;
        logic        e_err;
        e_dat = exp_q.pop_front();
        e_err = err_q.pop_front();
        total++;
        assert (rdata === e_dat) else begin
            bad++;
            $error("FAIL %s rdata observed=%h expected=%h", tag, rdata, e_dat);
        end
        total++;
        assert (align_err === e_err) else begin
            bad++;
            $error("FAIL %s align_err observed=%b expected=%b", tag, align_err, e_err);
        end
    endtask

    // Drive a load at the falling edge and check it shortly after.
    task automatic check_load(input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] e_dat, input logic e_err,
                              input string tag);
        @(negedge clk);
        WE   = 1'b0;
        op   = o;
        addr = a;
        exp_q.push_back(e_dat);
        err_q.push_back(e_err);
        #1;
        compare(tag);
    endtask

    // One-cycle store, released at the following falling edge.
    task automatic do_store(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] d);
        @(negedge clk);
        WE    = 1'b1;
        op    = o;
        addr  = a;
        wdata = d;
        pc    = pc + 32'd4;
        @(negedge clk);
        WE    = 1'b0;
    endtask

    logic [7:0]  lane_val [4];
    logic [31:0] lane_word;

    initial begin
        reset = 1'b1;
        WE    = 1'b0;
        op    = 3'b000;
        addr  = 32'h0;
        wdata = 32'h0;
        pc    = 32'h0000_3000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check_load(3'b000, 32'h0000_0010, 32'h0, 1'b0, "rst_w10");
        check_load(3'b100, 32'h0000_0103, 32'h0, 1'b0, "rst_b103");

        // Word store then load
        do_store(3'b000, 32'h0000_0010, 32'hDEAD_BEEF);
        check_load(3'b000, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "word_ld");

        // Byte store and extension
        do_store(3'b011, 32'h0000_0012, 32'h0000_0080);
        check_load(3'b000, 32'h0000_0010, 32'hDE80_BEEF, 1'b0, "byte_merge");
        check_load(3'b100, 32'h0000_0012, 32'hFFFF_FF80, 1'b0, "byte_sx");
        check_load(3'b011, 32'h0000_0012, 32'h0000_0080, 1'b0, "byte_zx");
        check_load(3'b100, 32'h0000_0013, 32'hFFFF_FFDE, 1'b0, "byte3_sx");

        // Halfword lanes
        do_store(3'b001, 32'h0000_0016, 32'h1234_ABCD);
        check_load(3'b000, 32'h0000_0014, 32'hABCD_0000, 1'b0, "half_merge");
        check_load(3'b010, 32'h0000_0016, 32'hFFFF_ABCD, 1'b0, "half_sx");
        check_load(3'b001, 32'h0000_0016, 32'h0000_ABCD, 1'b0, "half_zx");
        check_load(3'b010, 32'h0000_0014, 32'h0000_0000, 1'b0, "half_lo");
        check_load(3'b010, 32'h0000_0012, 32'hFFFF_DE80, 1'b0, "half_hi10");

        // Misaligned store is suppressed
        @(negedge clk);
        WE    = 1'b1;
        op    = 3'b000;
        addr  = 32'h0000_0011;
        wdata = 32'h5555_5555;
        exp_q.push_back(32'h0);
        err_q.push_back(1'b1);
        #1;
        compare("misalign_w");
        @(negedge clk);
        WE = 1'b0;
        check_load(3'b000, 32'h0000_0010, 32'hDE80_BEEF, 1'b0, "misalign_nowr");
        check_load(3'b001, 32'h0000_0013, 32'h0, 1'b1, "misalign_h");

        // Range boundary and reserved op codes
        check_load(3'b000, 32'(4 * DEPTH), 32'h0, 1'b1, "oob");
        check_load(3'b011, 32'h8000_0010, 32'h0, 1'b1, "oob_hi");
        check_load(3'b000, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, "last_word");
        check_load(3'b101, 32'h0000_0010, 32'h0, 1'b1, "rsv_101");
        check_load(3'b111, 32'h0000_0010, 32'h0, 1'b1, "rsv_111");
        do_store(3'b000, 32'(4 * DEPTH), 32'hAAAA_AAAA);
        do_store(3'b000, 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D);
        check_load(3'b000, 32'(4 * (DEPTH - 1)), 32'hCAFE_F00D, 1'b0, "last_wr");
        check_load(3'b000, 32'h0000_0000, 32'h0, 1'b0, "no_wrap");

        // Back-to-back byte stores accumulate in one word
        lane_val[0] = 8'h7F;
        lane_val[1] = 8'h80;
        lane_val[2] = 8'h01;
        lane_val[3] = 8'hFE;
        lane_word   = 32'h0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            WE    = 1'b1;
            op    = (i % 2 == 0) ? 3'b011 : 3'b100;
            addr  = 32'h0000_0030 + 32'(i);
            wdata = {24'hABCDEF, lane_val[i]};
            lane_word[i*8 +: 8] = lane_val[i];
            @(negedge clk);
        end
        WE = 1'b0;
        check_load(3'b000, 32'h0000_0030, lane_word, 1'b0, "lanes_word");
        for (int i = 0; i < 4; i++) begin
            check_load(3'b100, 32'h0000_0030 + 32'(i),
                       {{24{lane_val[i][7]}}, lane_val[i]}, 1'b0, $sformatf("lane%0d_sx", i));
        end

        // Read-during-write: old data before the edge, merged after
        do_store(3'b000, 32'h0000_0020, 32'h1111_1111);
        @(negedge clk);
        WE    = 1'b1;
        op    = 3'b000;
        addr  = 32'h0000_0020;
        wdata = 32'h2222_2222;
        exp_q.push_back(32'h1111_1111);
        err_q.push_back(1'b0);
        #1;
        compare("rdw_before");
        @(posedge clk);
        exp_q.push_back(32'h2222_2222);
        err_q.push_back(1'b0);
        #1;
        compare("rdw_after");
        WE = 1'b0;

        // Reset priority over a concurrent store
        @(negedge clk);
        reset = 1'b1;
        WE    = 1'b1;
        op    = 3'b000;
        addr  = 32'h0000_0010;
        wdata = 32'h0000_0001;
        @(negedge clk);
        reset = 1'b0;
        WE    = 1'b0;
        check_load(3'b000, 32'h0000_0010, 32'h0, 1'b0, "rstprio_w10");
        check_load(3'b000, 32'h0000_0020, 32'h0, 1'b0, "rstprio_w20");
        check_load(3'b000, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, "rstprio_last");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
